posicionador_frota: RTL and testbench

POSICIONADOR_FROTA -- requirements
Module: posicionador_frota

---
 rtl/posicionador_frota.sv | 170 +++++++++++++++++
 tb/tb_posicionador_frota.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/posicionador_frota.sv
// posicionador_frota: button-driven fleet placement FSM that walks through piece
// types, gathers orientation and anchor per piece, and rejects overlaps or out-of-bounds placements.
module posicionador_frota #(
    parameter int BOARD_N = 8,
    parameter int COORD_W = 3,
    parameter int QT_0 = 5,
    parameter int QT_1 = 2,
    parameter int QT_2 = 2,
    parameter int QT_3 = 1,
    parameter int QT_4 = 1,
    parameter int LEN_0 = 1,
    parameter int LEN_1 = 2,
    parameter int LEN_2 = 3,
    parameter int LEN_3 = 4,
    parameter int LEN_4 = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               enter,
    input  logic               select,
    input  logic               mode,
    input  logic               conflito,
    output logic               ready,
    output logic               valida,
    output logic [2:0]         tipo,
    output logic               jogador,
    output logic [COORD_W-1:0] X1,
    output logic [COORD_W-1:0] Y1,
    output logic               direcao,
    output logic               orientacao,
    output logic               grava,
    output logic               erro
);
    localparam int CW1 = COORD_W + 1;
    localparam logic [COORD_W-1:0] MAX_C = COORD_W'(BOARD_N - 1);
    localparam logic [CW1-1:0] MAX_W = CW1'(BOARD_N - 1);
    localparam bit NONE = (QT_0 == 0) && (QT_1 == 0) && (QT_2 == 0) && (QT_3 == 0) && (QT_4 == 0);

    typedef enum logic [2:0] {
        ST_IDLE, ST_DIRECAO, ST_ORIENTACAO, ST_DEF_X, ST_DEF_Y, ST_VERIFICA, ST_ARMAZENA, ST_PRONTO
    } state_t;

    function automatic logic [7:0] qt(input logic [2:0] t);
        qt = (t == 3'd0) ? 8'(QT_0) : (t == 3'd1) ? 8'(QT_1) : (t == 3'd2) ? 8'(QT_2) :
             (t == 3'd3) ? 8'(QT_3) : (t == 3'd4) ? 8'(QT_4) : 8'd0;
    endfunction

    function automatic logic [CW1-1:0] len(input logic [2:0] t);
        len = (t == 3'd0) ? CW1'(LEN_0) : (t == 3'd1) ? CW1'(LEN_1) : (t == 3'd2) ? CW1'(LEN_2) :
              (t == 3'd3) ? CW1'(LEN_3) : CW1'(LEN_4);
    endfunction

    // 3'd7 means no later type has pieces
    function automatic logic [2:0] next_type(input logic [2:0] t);
        next_type = 3'd7;
        for (int i = 4; i >= 0; i--)
            if (i > int'(t) && qt(3'(i)) != 8'd0) next_type = 3'(i);
    endfunction

    function automatic logic [2:0] first_type();
        first_type = 3'd0;
        for (int i = 4; i >= 0; i--)
            if (qt(3'(i)) != 8'd0) first_type = 3'(i);
    endfunction

    localparam logic [2:0] FIRST = first_type();

    state_t             state_q, state_d;
    logic               enter_q, select_q;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               dir_q, dir_d, ori_q, ori_d, jog_q, jog_d, erro_q, erro_d;
    logic [2:0]         tipo_q, tipo_d, nt;
    logic [7:0]         cnt_q, cnt_d;
    logic               ent, sel, oob;
    logic [CW1-1:0]     c_w, l_w;

    assign ent = enter_q & ~enter;
    assign sel = select_q & ~select & ~ent;
    assign c_w = {1'b0, dir_q ? y_q : x_q};
    assign l_w = len(tipo_q);
    assign oob = ori_q ? (c_w < l_w - CW1'(1)) : (c_w + l_w - CW1'(1) > MAX_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            enter_q  <= 1'b1;
            select_q <= 1'b1;
            x_q      <= '0;
            y_q      <= '0;
            dir_q    <= 1'b0;
            ori_q    <= 1'b0;
            jog_q    <= 1'b0;
            erro_q   <= 1'b0;
            tipo_q   <= FIRST;
            cnt_q    <= '0;
        end else begin
            enter_q  <= enter;
            select_q <= select;
            if (enable) begin
                state_q <= state_d;
                x_q     <= x_d;
                y_q     <= y_d;
                dir_q   <= dir_d;
                ori_q   <= ori_d;
                jog_q   <= jog_d;
                erro_q  <= erro_d;
                tipo_q  <= tipo_d;
                cnt_q   <= cnt_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        ori_d   = ori_q;
        jog_d   = jog_q;
        erro_d  = 1'b0;
        tipo_d  = tipo_q;
        cnt_d   = cnt_q;
        nt      = next_type(tipo_q);
        unique case (state_q)
            ST_IDLE:       state_d = NONE ? ST_PRONTO : ST_DIRECAO;
            ST_DIRECAO:    if (ent) state_d = ST_ORIENTACAO; else if (sel) dir_d = ~dir_q;
            ST_ORIENTACAO: if (ent) state_d = ST_DEF_X; else if (sel) ori_d = ~ori_q;
            ST_DEF_X:      if (ent) state_d = ST_DEF_Y; else if (sel) x_d = (x_q == MAX_C) ? '0 : x_q + COORD_W'(1);
            ST_DEF_Y:      if (ent) state_d = ST_VERIFICA; else if (sel) y_d = (y_q == MAX_C) ? '0 : y_q + COORD_W'(1);
            ST_VERIFICA: begin
                if (ent && (conflito || oob)) begin
                    erro_d  = 1'b1;
                    state_d = ST_DEF_X;
                end else if (ent) state_d = ST_ARMAZENA;
            end
            ST_ARMAZENA: begin
                if (ent) begin
                    x_d     = '0;
                    y_d     = '0;
                    dir_d   = 1'b0;
                    ori_d   = 1'b0;
                    state_d = ST_DIRECAO;
                    cnt_d   = cnt_q + 8'd1;
                    if (cnt_d == qt(tipo_q)) begin
                        cnt_d = '0;
                        if (nt != 3'd7) tipo_d = nt;
                        else if (mode && !jog_q) begin
                            jog_d  = 1'b1;
                            tipo_d = FIRST;
                        end else state_d = ST_PRONTO;
                    end
                end
            end
            default: ;
        endcase
    end

    // grava is taken while the piece fields are still valid, before they clear
    assign grava      = enable & ent & (state_q == ST_ARMAZENA);
    assign ready      = state_q == ST_PRONTO;
    assign valida     = state_q == ST_VERIFICA;
    assign erro       = erro_q;
    assign tipo       = tipo_q;
    assign jogador    = jog_q;
    assign X1         = x_q;
    assign Y1         = y_q;
    assign direcao    = dir_q;
    assign orientacao = ori_q;
endmodule

// File: tb/tb_posicionador_frota.sv
// tb_posicionador_frota: directed placement sequences against hand-computed results.
module tb_posicionador_frota;
    logic       clk = 1'b0;
    logic       reset = 1'b1, enable = 1'b0, enter = 1'b1, select = 1'b1, mode = 1'b0, conflito = 1'b0;
    logic       ready, valida, jogador, direcao, orientacao, grava, erro;
    logic [2:0] tipo;
    logic [2:0] X1, Y1;
    int         checks = 0, errors = 0, gcount = 0, g0;
    logic [2:0] tipo_log [0:127];
    logic       jog_log [0:127];
    int         exp_t [11] = '{0, 0, 0, 0, 0, 1, 1, 2, 2, 3, 4};

    posicionador_frota dut (
        .clk(clk), .reset(reset), .enable(enable), .enter(enter), .select(select), .mode(mode),
        .conflito(conflito), .ready(ready), .valida(valida), .tipo(tipo), .jogador(jogador),
        .X1(X1), .Y1(Y1), .direcao(direcao), .orientacao(orientacao), .grava(grava), .erro(erro)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (grava === 1'b1) begin
            tipo_log[gcount[6:0]] = tipo;
            jog_log[gcount[6:0]] = jogador;
            gcount++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_enter();
        @(posedge clk) #1 enter = 1'b0;
        @(posedge clk) #1 enter = 1'b1;
    endtask

    task automatic press_select(input int n);
        repeat (n) begin
            @(posedge clk) #1 select = 1'b0;
            @(posedge clk) #1 select = 1'b1;
        end
    endtask

    task automatic place(input int n);
        repeat (n) repeat (6) press_enter();
    endtask

    task automatic do_reset(input logic m);
        @(posedge clk) #1 reset = 1'b1;
        mode = m;
        @(posedge clk) #1 reset = 1'b0;
    endtask

    initial begin
        enable = 1'b1;
        tick(2);
        reset = 1'b0;
        chk("rst_ready", ready, 0);
        chk("rst_valida", valida, 0);
        chk("rst_erro", erro, 0);
        chk("rst_grava", grava, 0);
        chk("rst_tipo", tipo, 0);
        chk("rst_xy", {X1, Y1, direcao, orientacao, jogador}, 0);

        // single-player full fleet
        g0 = gcount;
        place(10);
        chk("m0_ready_early", ready, 0);
        place(1);
        chk("m0_count", gcount - g0, 11);
        chk("m0_ready", ready, 1);
        chk("m0_jog", jogador, 0);
        for (int i = 0; i < 11; i++) chk($sformatf("m0_tipo%0d", i), tipo_log[g0 + i], exp_t[i]);
        press_enter();
        press_select(1);
        chk("pronto_hold", {ready, 7'(gcount - g0)}, {1'b1, 7'd11});

        // two-player fleet
        do_reset(1'b1);
        g0 = gcount;
        place(21);
        chk("m1_ready21", ready, 0);
        chk("m1_jog21", jogador, 1);
        place(1);
        chk("m1_count", gcount - g0, 22);
        chk("m1_ready", ready, 1);
        chk("m1_jog10", jog_log[g0 + 10], 0);
        chk("m1_jog11", jog_log[g0 + 11], 1);
        chk("m1_tipo11", tipo_log[g0 + 11], 0);
        chk("m1_tipo21", tipo_log[g0 + 21], 4);

        // out-of-bounds on the longest piece
        do_reset(1'b0);
        place(10);
        chk("oob_tipo", tipo, 4);
        g0 = gcount;
        press_enter();
        press_enter();
        press_select(4);
        chk("oob_x4", X1, 4);
        press_enter();
        press_enter();
        chk("oob_valida", valida, 1);
        press_enter();
        chk("oob_erro", erro, 1);
        chk("oob_xkept", X1, 4);
        chk("oob_valida_off", valida, 0);
        tick(1);
        chk("oob_erro_pulse", erro, 0);
        press_select(7);
        chk("oob_x3", X1, 3);
        press_enter();
        press_enter();
        press_enter();
        chk("ok_no_erro", erro, 0);
        press_enter();
        chk("ok_grava", gcount - g0, 1);
        chk("ok_ready", ready, 1);

        // toggles, wrap, held button, enable gating, conflict
        do_reset(1'b0);
        g0 = gcount;
        press_select(1);
        chk("dir_tog", direcao, 1);
        press_select(1);
        chk("dir_tog2", direcao, 0);
        press_enter();
        press_select(1);
        chk("ori_tog", orientacao, 1);
        press_select(1);
        press_enter();
        press_select(8);
        chk("x_wrap", X1, 0);
        press_select(3);
        enable = 1'b0;
        press_select(2);
        enable = 1'b1;
        chk("en_hold", X1, 3);
        @(posedge clk) #1 enter = 1'b0;
        tick(20);
        enter = 1'b1;
        press_select(1);
        chk("held_once", {X1, Y1}, {3'd3, 3'd1});
        chk("held_valida", valida, 0);
        press_enter();
        conflito = 1'b1;
        press_enter();
        conflito = 1'b0;
        chk("cf_erro", erro, 1);
        chk("cf_nograva", gcount - g0, 0);
        press_select(1);
        chk("cf_defx", X1, 4);
        press_enter();
        press_enter();
        press_enter();
        press_enter();
        chk("cf_retry", gcount - g0, 1);
        chk("cf_clear", {X1, Y1}, 0);

        // reset mid-placement of player 1
        do_reset(1'b1);
        place(11);
        chk("p1_jog", jogador, 1);
        press_select(1);
        press_enter();
        press_enter();
        press_enter();
        press_select(1);
        chk("p1_y", {Y1, direcao}, {3'd1, 1'b1});
        do_reset(1'b1);
        chk("r2_out", {ready, valida, erro, grava, jogador, direcao, orientacao}, 0);
        chk("r2_xy", {X1, Y1, tipo}, 0);
        press_select(1);
        chk("r2_idle_dir", direcao, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
